// File: rtl/mult24_share_arbiter.sv
// mult24_share_arbiter: round-robin sharing of one 24x24 unsigned multiplier among NUM_REQ requesters.
// Define MULT24_ARB_PIPE_EN to add an operand register stage in front of the multiplier.
module mult24_share_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_REQ-1:0]    req_valid,
   output logic [NUM_REQ-1:0]    req_ready,
   input  logic [NUM_REQ*24-1:0] req_a,
   input  logic [NUM_REQ*24-1:0] req_b,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [ID_W-1:0]       rsp_id,
   output logic [47:0]           rsp_result,
   output logic                  busy
);

   typedef enum logic {SLOT_EMPTY = 1'b0, SLOT_FULL = 1'b1} slot_state_e;

   slot_state_e     state_q, state_d;
   logic [ID_W-1:0] ptr_q, ptr_d;
   logic [47:0]     result_q, result_d;
   logic [ID_W-1:0] rid_q, rid_d;

   logic            grant_found;
   logic [ID_W-1:0] grant_idx;
   logic [ID_W:0]   cand;
   logic            slot_can_load;
   logic            entry_ready;
   logic            accept;
   logic            slot_load;
   logic [23:0]     sel_a, sel_b;
   logic [23:0]     mul_a, mul_b;
   logic [ID_W-1:0] mul_id;
   logic [47:0]     product;

   // First valid requester at or after the pointer, wrapping modulo NUM_REQ.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      cand        = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = {1'b0, ptr_q} + (ID_W+1)'(k);
         if (cand >= (ID_W+1)'(NUM_REQ)) begin
            cand = cand - (ID_W+1)'(NUM_REQ);
         end
         if (!grant_found && req_valid[cand[ID_W-1:0]]) begin
            grant_found = 1'b1;
            grant_idx   = cand[ID_W-1:0];
         end
      end
   end

   assign slot_can_load = (state_q == SLOT_EMPTY) || rsp_ready;
   assign accept        = grant_found && entry_ready && !rst;
   assign sel_a         = req_a[24*grant_idx +: 24];
   assign sel_b         = req_b[24*grant_idx +: 24];
   assign product       = {24'b0, mul_a} * {24'b0, mul_b};

   always_comb begin
      req_ready = '0;
      if (accept) begin
         req_ready[grant_idx] = 1'b1;
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (accept) begin
         if (grant_idx == ID_W'(NUM_REQ-1)) begin
            ptr_d = '0;
         end else begin
            ptr_d = grant_idx + 1'b1;
         end
      end
   end

`ifdef MULT24_ARB_PIPE_EN
   logic            v1_q, v1_d;
   logic [23:0]     a_q, a_d;
   logic [23:0]     b_q, b_d;
   logic [ID_W-1:0] id_q, id_d;

   // Stage 1 frees up whenever its contents can move into the output slot.
   assign entry_ready = !v1_q || slot_can_load;
   assign slot_load   = v1_q && slot_can_load;
   assign mul_a       = a_q;
   assign mul_b       = b_q;
   assign mul_id      = id_q;
   assign busy        = v1_q || (state_q == SLOT_FULL);

   always_comb begin
      v1_d = v1_q;
      a_d  = a_q;
      b_d  = b_q;
      id_d = id_q;
      if (slot_load) begin
         v1_d = 1'b0;
      end
      if (accept) begin
         v1_d = 1'b1;
         a_d  = sel_a;
         b_d  = sel_b;
         id_d = grant_idx;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         v1_q <= 1'b0;
         a_q  <= '0;
         b_q  <= '0;
         id_q <= '0;
      end else begin
         v1_q <= v1_d;
         a_q  <= a_d;
         b_q  <= b_d;
         id_q <= id_d;
      end
   end
`else
   assign entry_ready = slot_can_load;
   assign slot_load   = accept;
   assign mul_a       = sel_a;
   assign mul_b       = sel_b;
   assign mul_id      = grant_idx;
   assign busy        = (state_q == SLOT_FULL);
`endif

   always_comb begin
      state_d  = state_q;
      result_d = result_q;
      rid_d    = rid_q;
      case (state_q)
         SLOT_EMPTY: if (slot_load) state_d = SLOT_FULL;
         SLOT_FULL:  if (rsp_ready && !slot_load) state_d = SLOT_EMPTY;
      endcase
      if (slot_load) begin
         result_d = product;
         rid_d    = mul_id;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= SLOT_EMPTY;
         ptr_q    <= '0;
         result_q <= '0;
         rid_q    <= '0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         result_q <= result_d;
         rid_q    <= rid_d;
      end
   end

   assign rsp_valid  = (state_q == SLOT_FULL);
   assign rsp_id     = rid_q;
   assign rsp_result = result_q;

endmodule

// File: tb/tb_mult24_share_arbiter.sv
// Self-checking bench for mult24_share_arbiter: randomized traffic against a queue-based reference model.
module tb_mult24_share_arbiter;
   localparam int N    = 4;
   localparam int ID_W = 2;
`ifdef MULT24_ARB_PIPE_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    req_valid;
   logic [N-1:0]    req_ready;
   wire  [N*24-1:0] req_a;
   wire  [N*24-1:0] req_b;
   logic            rsp_valid;
   logic            rsp_ready;
   logic [ID_W-1:0] rsp_id;
   logic [47:0]     rsp_result;
   logic            busy;

   logic [23:0] op_a [N];
   logic [23:0] op_b [N];

   for (genvar gi = 0; gi < N; gi++) begin : g_pack
      assign req_a[24*gi +: 24] = op_a[gi];
      assign req_b[24*gi +: 24] = op_b[gi];
   end

   mult24_share_arbiter #(.NUM_REQ(N)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_id(rsp_id), .rsp_result(rsp_result), .busy(busy)
   );

   always #5 clk = ~clk;

   // Reference model: occupancy of entry stage / output slot, round-robin pointer,
   // and a scoreboard of results in accept order (head = result in the output slot).
   bit          m_slot, m_s1;
   int          m_ptr;
   int          sb_id[$];
   logic [47:0] sb_res[$];
   bit          acc_now;
   int          last_acc;
   int          acc_cnt;
   int          n_checks = 0;
   int          n_fail   = 0;

   function automatic logic [N-1:0] exp_ready();
      logic [N-1:0] r;
      bit slot_free, entry_ok;
      int g;
      r = '0;
      if (rst) return r;
      slot_free = !m_slot || rsp_ready;
      entry_ok  = (LAT == 2) ? (!m_s1 || slot_free) : slot_free;
      for (int k = 0; k < N; k++) begin
         g = (m_ptr + k) % N;
         if (req_valid[g]) begin
            if (entry_ok) r[g] = 1'b1;
            break;
         end
      end
      return r;
   endfunction

   task automatic tick();
      logic [N-1:0] er;
      bit slot_free, n_slot, n_s1;
      er = exp_ready();
      acc_now = 1'b0;
      if (rst) begin
         m_slot = 0; m_s1 = 0; m_ptr = 0;
         sb_id.delete(); sb_res.delete();
      end else begin
         slot_free = !m_slot || rsp_ready;
         if (m_slot && rsp_ready) begin
            void'(sb_id.pop_front());
            void'(sb_res.pop_front());
         end
         if (LAT == 2) begin
            n_slot = (m_slot && !rsp_ready) || (m_s1 && slot_free);
            n_s1   = (er != 0) || (m_s1 && !slot_free);
         end else begin
            n_slot = (m_slot && !rsp_ready) || (er != 0);
            n_s1   = 0;
         end
         for (int g = 0; g < N; g++) begin
            if (er[g]) begin
               sb_id.push_back(g);
               sb_res.push_back(48'(longint'(op_a[g]) * longint'(op_b[g])));
               m_ptr    = (g + 1) % N;
               acc_now  = 1'b1;
               last_acc = g;
               acc_cnt++;
            end
         end
         m_slot = n_slot;
         m_s1   = n_s1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send_one(input int idx, input logic [23:0] a, input logic [23:0] b);
      req_valid = '0;
      req_valid[idx] = 1'b1;
      op_a[idx] = a;
      op_b[idx] = b;
      #2;
      tick();
      req_valid = '0;
   endtask

   task automatic drain_all();
      req_valid = '0;
      rsp_ready = 1'b1;
      repeat (LAT + 2) tick();
   endtask

   task automatic test_reset();
      rst = 1'b1; req_valid = '1; rsp_ready = 1'b1;
      for (int i = 0; i < N; i++) begin op_a[i] = 24'($urandom); op_b[i] = 24'($urandom); end
      #2;
      n_checks++; if (req_ready !== '0) begin n_fail++; $display("FAIL reset_req_ready got %b want 0", req_ready); end
      tick(); tick();
      n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
      n_checks++; if (rsp_id !== '0) begin n_fail++; $display("FAIL reset_rsp_id got %0d want 0", rsp_id); end
      n_checks++; if (rsp_result !== 48'h0) begin n_fail++; $display("FAIL reset_rsp_result got %h want 0", rsp_result); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
      rst = 1'b0; req_valid = '0;
      $display("reset: outputs idle after reset");
   endtask

   task automatic test_basic();
      req_valid = 4'b0010; op_a[1] = 24'h000003; op_b[1] = 24'h000005; rsp_ready = 1'b1;
      #2;
      n_checks++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL basic_req_ready got %b want 0010", req_ready); end
      tick();
      req_valid = '0;
      repeat (LAT - 1) tick();
      #2;
      n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL basic_rsp_valid got %b want 1", rsp_valid); end
      n_checks++; if (rsp_id !== 2'd1) begin n_fail++; $display("FAIL basic_rsp_id got %0d want 1", rsp_id); end
      n_checks++; if (rsp_result !== 48'h00000000000F) begin n_fail++; $display("FAIL basic_result got %h want 00000000000f", rsp_result); end
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy got %b want 1", busy); end
      tick();
      #2;
      n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL basic_drained got %b want 0", rsp_valid); end
      $display("basic: id=1 3*5 result=%h", 48'h00000000000F);
   endtask

   task automatic test_corners();
      send_one(0, 24'hFFFFFF, 24'hFFFFFF);
      repeat (LAT - 1) tick();
      #2;
      n_checks++; if (rsp_result !== 48'hFFFFFE000001) begin n_fail++; $display("FAIL max_result got %h want fffffe000001", rsp_result); end
      n_checks++; if (rsp_id !== 2'd0) begin n_fail++; $display("FAIL max_id got %0d want 0", rsp_id); end
      tick();
      send_one(2, 24'h000000, 24'hABCDEF);
      repeat (LAT - 1) tick();
      #2;
      n_checks++; if (rsp_valid !== 1'b1 || rsp_result !== 48'h0) begin n_fail++; $display("FAIL zero_result got v=%b %h want v=1 0", rsp_valid, rsp_result); end
      n_checks++; if (rsp_id !== 2'd2) begin n_fail++; $display("FAIL zero_id got %0d want 2", rsp_id); end
      tick();
      $display("corners: ffffff^2 and 0*abcdef");
   endtask

   task automatic test_round_robin();
      rst = 1'b1; tick(); rst = 1'b0;
      req_valid = '1; rsp_ready = 1'b1;
      for (int c = 0; c < 12; c++) begin
         #2;
         n_checks++; if (req_ready !== 4'(1 << (c % N))) begin n_fail++; $display("FAIL rr_grant c=%0d got %b want %b", c, req_ready, 4'(1 << (c % N))); end
         if (c >= LAT) begin
            n_checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== 2'((c - LAT) % N) || sb_res.size() == 0 || rsp_result !== sb_res[0]) begin
               n_fail++; $display("FAIL rr_rsp c=%0d got v=%b id=%0d %h want id=%0d", c, rsp_valid, rsp_id, rsp_result, (c - LAT) % N);
            end
         end
         tick();
         if (acc_now) begin op_a[last_acc] = 24'($urandom); op_b[last_acc] = 24'($urandom); end
      end
      drain_all();
      $display("round_robin: 12 back-to-back grants");
   endtask

   task automatic test_backpressure();
      int start_acc;
      logic [47:0] held;
      bit seen;
      seen = 0; held = '0;
      start_acc = acc_cnt;
      req_valid = '1; rsp_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         #2;
         n_checks++; if (req_ready !== exp_ready()) begin n_fail++; $display("FAIL bp_ready c=%0d got %b want %b", c, req_ready, exp_ready()); end
         if (rsp_valid === 1'b1) begin
            if (seen) begin
               n_checks++; if (rsp_result !== held) begin n_fail++; $display("FAIL bp_hold c=%0d got %h want %h", c, rsp_result, held); end
            end
            seen = 1; held = rsp_result;
         end
         tick();
      end
      #2;
      n_checks++; if (req_ready !== '0) begin n_fail++; $display("FAIL bp_all_blocked got %b want 0", req_ready); end
      n_checks++; if (acc_cnt - start_acc != LAT) begin n_fail++; $display("FAIL bp_accepts got %0d want %0d", acc_cnt - start_acc, LAT); end
      req_valid = '0; rsp_ready = 1'b1;
      for (int c = 0; c < LAT + 1; c++) begin
         #2;
         n_checks++;
         if (rsp_valid !== m_slot || (m_slot && (rsp_id !== 2'(sb_id[0]) || rsp_result !== sb_res[0]))) begin
            n_fail++; $display("FAIL bp_drain c=%0d got v=%b id=%0d %h", c, rsp_valid, rsp_id, rsp_result);
         end
         tick();
      end
      $display("backpressure: %0d accepts while stalled", LAT);
   endtask

   task automatic test_single();
      req_valid = 4'b1000; rsp_ready = 1'b1;
      for (int c = 0; c < 8; c++) begin
         #2;
         n_checks++; if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL single_grant c=%0d got %b want 1000", c, req_ready); end
         if (rsp_valid === 1'b1) begin
            n_checks++; if (rsp_id !== 2'd3 || rsp_result !== sb_res[0]) begin n_fail++; $display("FAIL single_rsp got id=%0d %h want id=3 %h", rsp_id, rsp_result, sb_res[0]); end
         end
         tick();
         op_a[3] = 24'($urandom); op_b[3] = 24'($urandom);
      end
      req_valid = 4'b1001;
      #2;
      n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL ptr_wrap got %b want 0001", req_ready); end
      req_valid = 4'b1000;
      drain_all();
      $display("single: requester 3 granted every cycle, ptr wrapped");
   endtask

   task automatic test_reset_inflight();
      rsp_ready = 1'b0;
      send_one(2, 24'($urandom), 24'($urandom));
      rst = 1'b1; tick(); rst = 1'b0;
      #2;
      n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_fly_valid got %b want 0", rsp_valid); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_fly_busy got %b want 0", busy); end
      req_valid = '1;
      #1;
      n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL rst_fly_ptr got %b want 0001", req_ready); end
      req_valid = '0; rsp_ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         #2;
         n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_fly_ghost c=%0d got %b want 0", c, rsp_valid); end
         tick();
      end
      $display("reset_inflight: dropped op never emerged");
   endtask

   task automatic test_random();
      for (int c = 0; c < 300; c++) begin
         for (int i = 0; i < N; i++) begin
            if (!req_valid[i] && ($urandom % 2 == 0)) begin
               req_valid[i] = 1'b1; op_a[i] = 24'($urandom); op_b[i] = 24'($urandom);
            end
         end
         rsp_ready = ($urandom % 4) != 0;
         #2;
         n_checks++; if (req_ready !== exp_ready()) begin n_fail++; $display("FAIL rnd_ready c=%0d got %b want %b", c, req_ready, exp_ready()); end
         n_checks++; if (rsp_valid !== m_slot || busy !== (m_slot || m_s1)) begin n_fail++; $display("FAIL rnd_valid c=%0d got v=%b busy=%b want v=%b busy=%b", c, rsp_valid, busy, m_slot, m_slot || m_s1); end
         if (m_slot && sb_id.size() > 0) begin
            n_checks++;
            if (rsp_id !== 2'(sb_id[0]) || rsp_result !== sb_res[0]) begin
               n_fail++; $display("FAIL rnd_rsp c=%0d got id=%0d %h want id=%0d %h", c, rsp_id, rsp_result, sb_id[0], sb_res[0]);
            end
         end
         tick();
         if (acc_now) req_valid[last_acc] = 1'b0;
      end
      drain_all();
      n_checks++; if (sb_id.size() != 0 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rnd_leftover got %0d pending v=%b want 0", sb_id.size(), rsp_valid); end
      $display("random: 300 cycles, %0d total accepts", acc_cnt);
   endtask

   initial begin
      m_slot = 0; m_s1 = 0; m_ptr = 0; acc_cnt = 0; last_acc = 0; acc_now = 0;
      rst = 1'b1; req_valid = '0; rsp_ready = 1'b0;
      for (int i = 0; i < N; i++) begin op_a[i] = '0; op_b[i] = '0; end
      @(posedge clk); #1;
      test_reset();
      test_basic();
      test_corners();
      test_round_robin();
      test_backpressure();
      test_single();
      test_reset_inflight();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
